// File: rtl/simon_pkg.sv
// Shared definitions for the sequence-memory game.
//   state_t   : round state machine encoding
//   STAT_*    : values driven on the 2-bit status output
//   sat_inc8  : 8-bit increment that sticks at 255 (round tallies)
package simon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER1 = 2'd1,
        ST_ENTER2 = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [1:0] STAT_NONE = 2'b00;
    localparam logic [1:0] STAT_LOSE = 2'b01;
    localparam logic [1:0] STAT_WIN  = 2'b11;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sec_countdown.sv
// Per-turn countdown: a prescaler divides cin down to one tick per second and
// a 0..9 seconds counter counts down on each tick.
//   cin     : clock
//   reset   : asynchronous, active-low
//   load    : reload prescaler (TICKS_PER_SEC-1) and seconds (TIME_SEC); wins over enable
//   enable  : count this cycle
//   seconds : remaining seconds, binary
//   timeout : high in the enabled cycle in which seconds steps from 1 to 0
module sec_countdown #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int TIME_SEC      = 9
) (
    input  logic       cin,
    input  logic       reset,
    input  logic       load,
    input  logic       enable,
    output logic [3:0] seconds,
    output logic       timeout
);

    localparam int              PRE_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]       SEC_INIT = 4'(TIME_SEC);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       sec_q, sec_d;

    // Combinational so the owning FSM can act on the expiry in the same cycle.
    assign timeout = enable && (pre_q == '0) && (sec_q == 4'd1);
    assign seconds = sec_q;

    always_comb begin
        pre_d = pre_q;
        sec_d = sec_q;
        if (load) begin
            pre_d = PRE_MAX;
            sec_d = SEC_INIT;
        end else if (enable) begin
            if (pre_q == '0) begin
                pre_d = PRE_MAX;
                if (sec_q != 4'd0) begin
                    sec_d = sec_q - 4'd1;
                end
            end else begin
                pre_d = pre_q - PRE_W'(1);
            end
        end
    end

    always_ff @(posedge cin or negedge reset) begin
        if (!reset) begin
            pre_q <= PRE_MAX;
            sec_q <= SEC_INIT;
        end else begin
            pre_q <= pre_d;
            sec_q <= sec_d;
        end
    end

endmodule

// File: rtl/simon_seq_game.sv
// Two-player sequence memory game. Player 1 stores up to DEPTH switch
// patterns, player 2 must replay them in order before the countdown expires.
//   cin, reset           : clock, asynchronous active-low reset
//   start, commit, end1  : one-cycle control pulses
//   sw                   : switch pattern
//   status               : 00 none, 01 lose, 11 win (valid in RESULT)
//   turn                 : 0 player 1, 1 player 2
//   seconds              : remaining seconds of the current turn
//   switch_LEDs          : registered sw while entering, else 0
//   seq_len              : steps stored by player 1
//   p1_score, p2_score   : saturating tallies (lose -> p1, win -> p2)
module simon_seq_game
    import simon_pkg::*;
#(
    parameter int SW_W          = 8,
    parameter int DEPTH         = 16,
    parameter int TICKS_PER_SEC = 50000000,
    parameter int TIME_SEC      = 9
) (
    input  logic                       cin,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       commit,
    input  logic                       end1,
    input  logic [SW_W-1:0]            sw,
    output logic [1:0]                 status,
    output logic                       turn,
    output logic [3:0]                 seconds,
    output logic [SW_W-1:0]            switch_LEDs,
    output logic [$clog2(DEPTH+1)-1:0] seq_len,
    output logic [7:0]                 p1_score,
    output logic [7:0]                 p2_score
);

    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state_q, state_d;
    logic [1:0]       status_q, status_d;
    logic [LEN_W-1:0] seq_len_q, seq_len_d;
    logic [LEN_W-1:0] index_q, index_d;
    logic [LEN_W-1:0] len_after;
    logic [SW_W-1:0]  switch_leds_q, switch_leds_d;
    logic [7:0]       p1_score_q, p1_score_d;
    logic [7:0]       p2_score_q, p2_score_d;

    logic [SW_W-1:0]  mem_q [DEPTH];
    logic             mem_we;
    logic [SW_W-1:0]  rd_data;

    logic             entering;
    logic             tmr_load;
    logic             timeout;

    sec_countdown #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .TIME_SEC      (TIME_SEC)
    ) u_countdown (
        .cin     (cin),
        .reset   (reset),
        .load    (tmr_load),
        .enable  (entering),
        .seconds (seconds),
        .timeout (timeout)
    );

    assign entering = (state_q == ST_ENTER1) || (state_q == ST_ENTER2);

    // Index never reaches DEPTH while in ENTER2, so the low bits address the array.
    assign rd_data = mem_q[index_q[IDX_W-1:0]];

    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        seq_len_d     = seq_len_q;
        index_d       = index_q;
        p1_score_d    = p1_score_q;
        p2_score_d    = p2_score_q;
        mem_we        = 1'b0;
        tmr_load      = 1'b0;
        len_after     = seq_len_q;
        switch_leds_d = entering ? sw : '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_ENTER1;
                    seq_len_d = '0;
                    index_d   = '0;
                    tmr_load  = 1'b1;
                end
            end

            ST_ENTER1: begin
                if (commit && (seq_len_q < LEN_W'(DEPTH))) begin
                    mem_we    = 1'b1;
                    len_after = seq_len_q + LEN_W'(1);
                end
                seq_len_d = len_after;
                // A commit in the same cycle counts towards the non-empty test.
                if ((end1 || timeout) && (len_after != '0)) begin
                    state_d  = ST_ENTER2;
                    index_d  = '0;
                    tmr_load = 1'b1;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end

            ST_ENTER2: begin
                // Commit is judged before timeout: a completing match still wins.
                if (commit && (rd_data != sw)) begin
                    state_d    = ST_RESULT;
                    status_d   = STAT_LOSE;
                    p1_score_d = sat_inc8(p1_score_q);
                end else if (commit && (index_q == seq_len_q - LEN_W'(1))) begin
                    state_d    = ST_RESULT;
                    status_d   = STAT_WIN;
                    p2_score_d = sat_inc8(p2_score_q);
                end else if (timeout) begin
                    state_d    = ST_RESULT;
                    status_d   = STAT_LOSE;
                    p1_score_d = sat_inc8(p1_score_q);
                end else if (commit) begin
                    index_d = index_q + LEN_W'(1);
                end
            end

            ST_RESULT: begin
                if (start) begin
                    state_d   = ST_ENTER1;
                    status_d  = STAT_NONE;
                    seq_len_d = '0;
                    index_d   = '0;
                    tmr_load  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cin or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            status_q      <= STAT_NONE;
            seq_len_q     <= '0;
            index_q       <= '0;
            switch_leds_q <= '0;
            p1_score_q    <= '0;
            p2_score_q    <= '0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            seq_len_q     <= seq_len_d;
            index_q       <= index_d;
            switch_leds_q <= switch_leds_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
        end
    end

    // Sequence storage carries no reset; entries past seq_len are never read.
    always_ff @(posedge cin) begin
        if (mem_we) begin
            mem_q[seq_len_q[IDX_W-1:0]] <= sw;
        end
    end

    assign status      = status_q;
    assign turn        = (state_q == ST_ENTER2) || (state_q == ST_RESULT);
    assign switch_LEDs = switch_leds_q;
    assign seq_len     = seq_len_q;
    assign p1_score    = p1_score_q;
    assign p2_score    = p2_score_q;

endmodule

// File: tb/tb_simon_seq_game.sv
// Randomised plus directed bench for simon_seq_game with a round-level
// reference model (phase, stored-step queue, elapsed-cycle timer).
module tb_simon_seq_game;

    localparam int SW_W  = 8;
    localparam int DEPTH = 4;
    localparam int TICKS = 4;
    localparam int TSEC  = 9;

    logic            cin = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            commit = 1'b0;
    logic            end1 = 1'b0;
    logic [SW_W-1:0] sw = '0;
    logic [1:0]      status;
    logic            turn;
    logic [3:0]      seconds;
    logic [SW_W-1:0] switch_LEDs;
    logic [2:0]      seq_len;
    logic [7:0]      p1_score;
    logic [7:0]      p2_score;

    simon_seq_game #(
        .SW_W          (SW_W),
        .DEPTH         (DEPTH),
        .TICKS_PER_SEC (TICKS),
        .TIME_SEC      (TSEC)
    ) dut (
        .cin         (cin),
        .reset       (reset),
        .start       (start),
        .commit      (commit),
        .end1        (end1),
        .sw          (sw),
        .status      (status),
        .turn        (turn),
        .seconds     (seconds),
        .switch_LEDs (switch_LEDs),
        .seq_len     (seq_len),
        .p1_score    (p1_score),
        .p2_score    (p2_score)
    );

    always #5 cin = ~cin;

    int n_checks = 0;
    int n_errors = 0;
    bit verbose  = 1'b1;

    // Reference model: 0 idle, 1 player-1 entry, 2 player-2 replay, 3 result
    int              m_phase;
    logic [SW_W-1:0] m_seq[$];
    int              m_idx;
    int              m_elapsed;
    int              m_seconds;
    int              m_status;
    int              m_p1;
    int              m_p2;
    int              m_leds;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase   = 0;
        m_seq.delete();
        m_idx     = 0;
        m_elapsed = 0;
        m_seconds = TSEC;
        m_status  = 0;
        m_p1      = 0;
        m_p2      = 0;
        m_leds    = 0;
    endfunction

    function automatic void begin_round();
        m_phase   = 1;
        m_status  = 0;
        m_seq.delete();
        m_idx     = 0;
        m_elapsed = 0;
        m_seconds = TSEC;
    endfunction

    function automatic void finish_round(input bit win);
        m_phase = 3;
        if (win) begin
            m_status = 3;
            if (m_p2 < 255) m_p2++;
        end else begin
            m_status = 1;
            if (m_p1 < 255) m_p1++;
        end
    endfunction

    function automatic void model_step(input bit st, input bit cm, input bit e1, input logic [SW_W-1:0] s);
        bit active;
        bit to;
        active = (m_phase == 1) || (m_phase == 2);
        m_leds = active ? int'(s) : 0;
        if (active) begin
            m_elapsed++;
            m_seconds = TSEC - m_elapsed / TICKS;
        end
        to = active && (m_elapsed == TSEC * TICKS);
        case (m_phase)
            0: if (st) begin_round();
            1: begin
                if (cm && m_seq.size() < DEPTH) m_seq.push_back(s);
                if ((e1 || to) && m_seq.size() > 0) begin
                    m_phase   = 2;
                    m_idx     = 0;
                    m_elapsed = 0;
                    m_seconds = TSEC;
                end else if (to) begin
                    m_phase = 0;
                end
            end
            2: begin
                if (cm && s != m_seq[m_idx]) finish_round(1'b0);
                else if (cm && m_idx == m_seq.size() - 1) finish_round(1'b1);
                else if (to) finish_round(1'b0);
                else if (cm) m_idx++;
            end
            default: if (st) begin_round();
        endcase
    endfunction

    task automatic check_all();
        check("status",  32'(status),      32'(m_status));
        check("turn",    32'(turn),        32'(m_phase >= 2));
        check("seconds", 32'(seconds),     32'(m_seconds));
        check("leds",    32'(switch_LEDs), 32'(m_leds));
        check("seq_len", 32'(seq_len),     32'(m_seq.size()));
        check("p1",      32'(p1_score),    32'(m_p1));
        check("p2",      32'(p2_score),    32'(m_p2));
    endtask

    // One clock cycle: apply pulses, clock, advance model, compare everything.
    task automatic step(input bit st, input bit cm, input bit e1, input logic [SW_W-1:0] s);
        start  = st;
        commit = cm;
        end1   = e1;
        sw     = s;
        @(posedge cin);
        #1;
        model_step(st, cm, e1, s);
        start  = 1'b0;
        commit = 1'b0;
        end1   = 1'b0;
        check_all();
        if (verbose && (st || cm || e1))
            $display("txn t=%0t start=%0b commit=%0b end1=%0b sw=%02h -> status=%02b turn=%0b sec=%0d len=%0d p1=%0d p2=%0d",
                     $time, st, cm, e1, s, status, turn, seconds, seq_len, p1_score, p2_score);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [SW_W-1:0] pat [5];
        logic [SW_W-1:0] s;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44; pat[4] = 8'h55;

        // Reset state
        model_reset();
        sw = 8'hA5;
        repeat (2) @(posedge cin);
        #1;
        check_all();
        check("rst_seconds", 32'(seconds), 32'd9);
        reset = 1'b1;
        idle(2);

        // Win with three-step sequence
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h82);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h82);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        check("win_status", 32'(status), 32'h3);
        check("win_p2",     32'(p2_score), 32'd1);
        check("win_turn",   32'(turn), 32'd1);

        // Mismatch on second replay step loses; later commits ignored
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("restart_status", 32'(status), 32'h0);
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h82);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h83);
        check("lose_status", 32'(status), 32'h1);
        check("lose_p1",     32'(p1_score), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        check("lose_hold", 32'(status), 32'h1);

        // Overfill: fifth commit dropped, full replay wins
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, pat[i]);
        check("full_len", 32'(seq_len), 32'd4);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, pat[i]);
        check("full_win", 32'(status), 32'h3);
        check("full_p2",  32'(p2_score), 32'd2);

        // Empty turn times out back to idle
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(35);
        check("pre_to_seconds", 32'(seconds), 32'd1);
        idle(1);
        check("to_idle_seconds", 32'(seconds), 32'd0);
        check("to_idle_status",  32'(status), 32'h0);
        check("to_idle_turn",    32'(turn), 32'd0);
        idle(2);
        // One stored step: timeout hands over, then replay timeout loses
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hA5);
        idle(35);
        check("handover_turn",    32'(turn), 32'd1);
        check("handover_seconds", 32'(seconds), 32'd9);
        idle(36);
        check("replay_to_status", 32'(status), 32'h1);
        check("replay_to_p1",     32'(p1_score), 32'd2);

        // Final match on the timeout cycle still wins
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h55);
        idle(35);
        step(1'b0, 1'b1, 1'b0, 8'h55);
        check("edge_win", 32'(status), 32'h3);

        // Score saturation
        verbose = 1'b0;
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            step(1'b0, 1'b1, 1'b1, 8'h3C);
            step(1'b0, 1'b1, 1'b0, 8'h3C);
        end
        check("sat_p2", 32'(p2_score), 32'd255);
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            step(1'b0, 1'b1, 1'b1, 8'h3C);
            step(1'b0, 1'b1, 1'b0, 8'hC3);
        end
        check("sat_p1", 32'(p1_score), 32'd255);
        verbose = 1'b1;

        // Asynchronous reset mid-replay abandons the round
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h77);
        idle(5);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check("arst_seconds", 32'(seconds), 32'd9);
        check("arst_p1",      32'(p1_score), 32'd0);
        check("arst_turn",    32'(turn), 32'd0);
        @(posedge cin);
        #1;
        reset = 1'b1;
        idle(2);

        // Random play against the model
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit st, cm, e1;
            st = ($urandom_range(0, 11) == 0);
            cm = ($urandom_range(0, 2) == 0);
            e1 = ($urandom_range(0, 9) == 0);
            if (m_phase == 2 && $urandom_range(0, 3) != 0) s = m_seq[m_idx];
            else if ($urandom_range(0, 1) == 0) s = pat[$urandom_range(0, 4)];
            else s = 8'($urandom_range(0, 255));
            step(st, cm, e1, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
